// File: rtl/wiener_pkg.sv
// Shared types and sizing helpers for the Wiener block statistics slice.
// The accumulator widths are chosen so a full block can never overflow.
package wiener_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    localparam int unsigned LOG2_SAMPLES_DEF = 32'd3;
    localparam int unsigned SAMPLES          = 32'd1 << LOG2_SAMPLES_DEF;

    function automatic int unsigned samples(input int unsigned log2_samples);
        return 32'd1 << log2_samples;
    endfunction

    function automatic int unsigned sum_width(input int unsigned dw, input int unsigned log2_samples);
        return dw + log2_samples;
    endfunction

    function automatic int unsigned sumsq_width(input int unsigned dw, input int unsigned log2_samples);
        return 32'd2 * dw + log2_samples;
    endfunction

endpackage

// File: rtl/wiener_block_stats_mc_ch_accum.sv
// One channel of block statistics: sum / sum-of-squares accumulation followed by
// a two-stage mean and variance pipeline whose results hold until the next block.
module wiener_ch_accum
    import wiener_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int LOG2_SAMPLES = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic                      acc_i,
    input  logic                      close_i,
    input  logic [DATA_WIDTH-1:0]     sample_i,
    output logic [2*DATA_WIDTH-1:0]   mean_o,
    output logic [2*DATA_WIDTH-1:0]   var_o
);

    localparam int SW = sum_width(DATA_WIDTH, LOG2_SAMPLES);
    localparam int QW = sumsq_width(DATA_WIDTH, LOG2_SAMPLES);
    localparam int MW = 2 * DATA_WIDTH;

    logic [SW-1:0]         sum_q, sum_d;
    logic [QW-1:0]         sumsq_q, sumsq_d;
    logic [QW-1:0]         sq_s;
    logic                  close_q;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] mean1_q, mean1_d;
    logic [MW-1:0]         msq_q, msq_d;
    logic [MW-1:0]         mean_sq_s;
    logic [MW-1:0]         mean_q, var_q, var_d;

    // Accumulator next state: the cycle after a block closes restarts from zero
    always_comb begin
        sq_s = QW'(sample_i) * QW'(sample_i);
        if (clear_i || close_q) begin
            sum_d   = '0;
            sumsq_d = '0;
        end else begin
            sum_d   = sum_q;
            sumsq_d = sumsq_q;
        end
        if (acc_i) begin
            sum_d   = sum_d + SW'(sample_i);
            sumsq_d = sumsq_d + sq_s;
        end else begin
            sum_d   = sum_d;
            sumsq_d = sumsq_d;
        end
    end

    // Stage 1 divides by the block size; stage 2 forms E[x^2] - E[x]^2, floored at zero
    always_comb begin
        mean1_d   = DATA_WIDTH'(sum_q >> LOG2_SAMPLES);
        msq_d     = MW'(sumsq_q >> LOG2_SAMPLES);
        mean_sq_s = MW'(mean1_q) * MW'(mean1_q);
        if (msq_q >= mean_sq_s) begin
            var_d = msq_q - mean_sq_s;
        end else begin
            var_d = '0;
        end
    end

    // Accumulator and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            sumsq_q    <= '0;
            close_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            mean1_q    <= '0;
            msq_q      <= '0;
            mean_q     <= '0;
            var_q      <= '0;
        end else begin
            sum_q      <= sum_d;
            sumsq_q    <= sumsq_d;
            close_q    <= close_i;
            s1_valid_q <= close_q;
            if (close_q) begin
                mean1_q <= mean1_d;
                msq_q   <= msq_d;
            end
            if (s1_valid_q) begin
                mean_q <= MW'(mean1_q);
                var_q  <= var_d;
            end
        end
    end

    assign mean_o = mean_q;
    assign var_o  = var_q;

endmodule

// File: rtl/wiener_block_stats_mc.sv
// Multi-channel block statistics with ping-pong replay so each block's pixels
// leave the module starting in the same cycle as their own mean/variance.
module wiener_block_stats_mc
    import wiener_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CH       = 3,
    parameter int LOG2_SAMPLES = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_of_frame,
    input  logic                             end_of_frame,
    input  logic                             data_valid,
    input  logic                             start_data,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     data_in,
    input  logic [31:0]                      blocks_per_frame,
    output logic [NUM_CH*2*DATA_WIDTH-1:0]   mean_out,
    output logic [NUM_CH*2*DATA_WIDTH-1:0]   variance_out,
    output logic                             stats_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0]     data_out,
    output logic                             data_out_valid,
    output logic                             frame_done,
    output logic                             block_error
);

    localparam int PW    = NUM_CH * DATA_WIDTH;
    localparam int MW    = 2 * DATA_WIDTH;
    localparam int L     = LOG2_SAMPLES;
    localparam int DEPTH = 2 * samples(LOG2_SAMPLES);
    localparam logic [L-1:0] CNT_ONE = L'(1);

    state_t          state_q, state_d;
    logic            stop_q, stop_d;
    logic [L-1:0]    sample_cnt_q, sample_cnt_d;
    logic [31:0]     block_cnt_q, block_cnt_d;
    logic            wr_bank_q, wr_bank_d;
    logic            block_error_q, block_error_d;
    logic            close_q, close_last_q, close_bank_q;
    logic            s1_valid_q, s1_last_q, s1_bank_q;
    logic            stats_valid_q, frame_done_q;
    logic            rd_active_q, rd_active_d;
    logic [L-1:0]    rd_cnt_q, rd_cnt_d;
    logic            rd_bank_q, rd_bank_d;
    logic [PW-1:0]   data_out_q;
    logic            data_out_valid_q;
    logic [PW-1:0]   mem_q [DEPTH];

    logic            running_s, accept_s, restart_s, close_s, last_s, clear_s, busy_s, rd_go_s;
    logic [L-1:0]    eff_cnt_s;
    logic [31:0]     blk_next_s;
    logic [L:0]      wr_addr_s, rd_addr_s;

    // Sample qualification: a start_data mid-block restarts at index 0
    always_comb begin
        running_s = (state_q == RUN) && !stop_q;
        accept_s  = data_valid && !end_of_frame && (start_of_frame || running_s);
        restart_s = accept_s && start_data && !start_of_frame && (sample_cnt_q != '0);
        if (start_of_frame || restart_s) begin
            eff_cnt_s = '0;
        end else begin
            eff_cnt_s = sample_cnt_q;
        end
        close_s = accept_s && (eff_cnt_s == '1);
        clear_s = start_of_frame || end_of_frame || restart_s;
        if (start_of_frame) begin
            blk_next_s = 32'd1;
        end else begin
            blk_next_s = block_cnt_q + 32'd1;
        end
        last_s    = close_s && (blocks_per_frame != 32'd0) && (blk_next_s == blocks_per_frame);
        wr_addr_s = {wr_bank_q, eff_cnt_s};
        busy_s    = close_q || s1_valid_q || rd_active_q;
    end

    // Counters, bank select, error flag and frame FSM
    always_comb begin
        if (accept_s) begin
            sample_cnt_d = eff_cnt_s + CNT_ONE;
        end else if (clear_s) begin
            sample_cnt_d = '0;
        end else begin
            sample_cnt_d = sample_cnt_q;
        end

        if (close_s) begin
            block_cnt_d = blk_next_s;
        end else if (start_of_frame) begin
            block_cnt_d = 32'd0;
        end else begin
            block_cnt_d = block_cnt_q;
        end

        if (close_s) begin
            wr_bank_d = ~wr_bank_q;
        end else begin
            wr_bank_d = wr_bank_q;
        end

        if (start_of_frame) begin
            block_error_d = 1'b0;
        end else if (restart_s) begin
            block_error_d = 1'b1;
        end else begin
            block_error_d = block_error_q;
        end

        // stop_q blocks new samples while RUN lingers for the replay to drain
        if (start_of_frame) begin
            state_d = RUN;
            stop_d  = last_s;
        end else begin
            case (state_q)
                RUN: begin
                    if (stop_q && !busy_s) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = RUN;
                        stop_d  = stop_q || end_of_frame || last_s;
                    end
                end
                default: begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end
            endcase
        end
    end

    // Replay sequencer: entry 0 is read as stage 1 completes so it lands with stats_valid
    always_comb begin
        rd_go_s = s1_valid_q || rd_active_q;
        if (s1_valid_q) begin
            rd_addr_s   = {s1_bank_q, {L{1'b0}}};
            rd_active_d = 1'b1;
            rd_cnt_d    = CNT_ONE;
            rd_bank_d   = s1_bank_q;
        end else if (rd_active_q) begin
            rd_addr_s   = {rd_bank_q, rd_cnt_q};
            rd_active_d = (rd_cnt_q != '1);
            rd_cnt_d    = rd_cnt_q + CNT_ONE;
            rd_bank_d   = rd_bank_q;
        end else begin
            rd_addr_s   = {rd_bank_q, rd_cnt_q};
            rd_active_d = 1'b0;
            rd_cnt_d    = '0;
            rd_bank_d   = rd_bank_q;
        end
    end

    // Control, pipeline tag and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            stop_q           <= 1'b0;
            sample_cnt_q     <= '0;
            block_cnt_q      <= 32'd0;
            wr_bank_q        <= 1'b0;
            block_error_q    <= 1'b0;
            close_q          <= 1'b0;
            close_last_q     <= 1'b0;
            close_bank_q     <= 1'b0;
            s1_valid_q       <= 1'b0;
            s1_last_q        <= 1'b0;
            s1_bank_q        <= 1'b0;
            stats_valid_q    <= 1'b0;
            frame_done_q     <= 1'b0;
            rd_active_q      <= 1'b0;
            rd_cnt_q         <= '0;
            rd_bank_q        <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            stop_q           <= stop_d;
            sample_cnt_q     <= sample_cnt_d;
            block_cnt_q      <= block_cnt_d;
            wr_bank_q        <= wr_bank_d;
            block_error_q    <= block_error_d;
            close_q          <= close_s;
            close_last_q     <= last_s;
            close_bank_q     <= wr_bank_q;
            s1_valid_q       <= close_q;
            s1_last_q        <= close_last_q;
            s1_bank_q        <= close_bank_q;
            stats_valid_q    <= s1_valid_q;
            frame_done_q     <= s1_valid_q && s1_last_q;
            rd_active_q      <= rd_active_d;
            rd_cnt_q         <= rd_cnt_d;
            rd_bank_q        <= rd_bank_d;
            data_out_valid_q <= rd_go_s;
            if (rd_go_s) begin
                data_out_q <= mem_q[rd_addr_s];
            end
        end
    end

    // Ping-pong replay RAM write port
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_addr_s] <= data_in;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wiener_ch_accum #(
            .DATA_WIDTH   (DATA_WIDTH),
            .LOG2_SAMPLES (LOG2_SAMPLES)
        ) u_accum (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear_i  (clear_s),
            .acc_i    (accept_s),
            .close_i  (close_s),
            .sample_i (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .mean_o   (mean_out[c*MW +: MW]),
            .var_o    (variance_out[c*MW +: MW])
        );
    end

    assign stats_valid    = stats_valid_q;
    assign frame_done     = frame_done_q;
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign block_error    = block_error_q;

endmodule

// File: tb/tb_wiener_block_stats_mc.sv
// Self-checking bench: a cycle-indexed reference model predicts every stats,
// replay and frame event from the block rules; outputs are compared each cycle.
module tb_wiener_block_stats_mc;

    localparam int DW   = 8;
    localparam int NCH  = 3;
    localparam int L    = 3;
    localparam int NS   = 8;
    localparam int PW   = NCH * DW;
    localparam int MW   = 2 * DW;
    localparam int MAXC = 8192;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sof, eof, dv, sd;
    logic [PW-1:0]     din;
    logic [31:0]       bpf;
    logic [NCH*MW-1:0] mean_out, variance_out;
    logic              stats_valid, data_out_valid, frame_done, block_error;
    logic [PW-1:0]     data_out;

    wiener_block_stats_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .LOG2_SAMPLES(L)) dut (
        .clk(clk), .rst_n(rst_n), .start_of_frame(sof), .end_of_frame(eof),
        .data_valid(dv), .start_data(sd), .data_in(din), .blocks_per_frame(bpf),
        .mean_out(mean_out), .variance_out(variance_out), .stats_valid(stats_valid),
        .data_out(data_out), .data_out_valid(data_out_valid), .frame_done(frame_done),
        .block_error(block_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    bit                exp_sv [MAXC];
    bit                exp_fd [MAXC];
    bit                exp_dov[MAXC];
    logic [PW-1:0]     exp_do  [MAXC];
    logic [NCH*MW-1:0] exp_mean[MAXC];
    logic [NCH*MW-1:0] exp_var [MAXC];

    bit                m_run, m_berr;
    int                m_cnt, m_blocks;
    logic [PW-1:0]     m_blk[NS];
    logic [NCH*MW-1:0] hold_mean, hold_var;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    endtask

    function automatic logic [PW-1:0] pack3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic check_outputs();
        if (exp_sv[cyc]) begin
            hold_mean = exp_mean[cyc];
            hold_var  = exp_var[cyc];
        end
        check_val("stats_valid",    64'(stats_valid),    64'(exp_sv[cyc]));
        check_val("frame_done",     64'(frame_done),     64'(exp_fd[cyc]));
        check_val("data_out_valid", 64'(data_out_valid), 64'(exp_dov[cyc]));
        check_val("block_error",    64'(block_error),    64'(m_berr));
        check_val("mean_out",       64'(mean_out),       64'(hold_mean));
        check_val("variance_out",   64'(variance_out),   64'(hold_var));
        if (exp_dov[cyc]) check_val("data_out", 64'(data_out), 64'(exp_do[cyc]));
    endtask

    // Block of NS samples completed at edge e: predict stats at e+2 and replay e+2..e+NS+1.
    task automatic model_close(input int e);
        int s, q, v, mn, vr;
        exp_mean[e+2] = '0;
        exp_var[e+2]  = '0;
        for (int c = 0; c < NCH; c++) begin
            s = 0;
            q = 0;
            for (int i = 0; i < NS; i++) begin
                v = int'(m_blk[i][c*DW +: DW]);
                s = s + v;
                q = q + v * v;
            end
            mn = s / NS;
            vr = q / NS - mn * mn;
            if (vr < 0) vr = 0;
            exp_mean[e+2][c*MW +: MW] = MW'(mn);
            exp_var[e+2][c*MW +: MW]  = MW'(vr);
        end
        exp_sv[e+2] = 1'b1;
        for (int i = 0; i < NS; i++) begin
            exp_dov[e+2+i] = 1'b1;
            exp_do[e+2+i]  = m_blk[i];
        end
        m_blocks++;
        if (bpf != 0 && m_blocks == int'(bpf)) begin
            exp_fd[e+2] = 1'b1;
            m_run = 1'b0;
        end
    endtask

    task automatic model_step(input int e, input bit s_sof, input bit s_eof, input bit s_dv,
                              input bit s_sd, input logic [PW-1:0] d);
        if (s_sof) begin
            m_run = 1'b1; m_cnt = 0; m_blocks = 0; m_berr = 1'b0;
        end
        if (s_eof) begin
            m_run = 1'b0; m_cnt = 0;
        end else if (s_dv && m_run) begin
            if (s_sd && m_cnt != 0) begin
                m_berr = 1'b1; m_cnt = 0;
            end
            m_blk[m_cnt] = d;
            m_cnt++;
            if (m_cnt == NS) begin
                m_cnt = 0;
                model_close(e);
            end
        end
    endtask

    task automatic step(input bit s_sof, input bit s_eof, input bit s_dv, input bit s_sd,
                        input logic [PW-1:0] d);
        @(negedge clk);
        check_outputs();
        if (cyc + NS + 4 >= MAXC) begin
            $display("FAIL cycle_budget: got %0d, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        sof = s_sof; eof = s_eof; dv = s_dv; sd = s_sd; din = d;
        model_step(cyc + 1, s_sof, s_eof, s_dv, s_sd, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic rand_block(input bit with_sof);
        for (int i = 0; i < NS; i++)
            step(with_sof && i == 0, 1'b0, 1'b1, i == 0, PW'($urandom));
    endtask

    task automatic reset_mid_block();
        @(negedge clk);
        check_outputs();
        sof = 1'b0; eof = 1'b0; dv = 1'b0; sd = 1'b0; din = '0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = cyc + 1; i < MAXC; i++) begin
            exp_sv[i] = 1'b0; exp_fd[i] = 1'b0; exp_dov[i] = 1'b0;
        end
        m_run = 1'b0; m_cnt = 0; m_blocks = 0; m_berr = 1'b0;
        hold_mean = '0; hold_var = '0;
        check_val("rst_stats_valid", 64'(stats_valid),    64'd0);
        check_val("rst_dov",         64'(data_out_valid), 64'd0);
        check_val("rst_data_out",    64'(data_out),       64'd0);
        check_val("rst_mean",        64'(mean_out),       64'd0);
        check_val("rst_var",         64'(variance_out),   64'd0);
        check_val("rst_block_error", 64'(block_error),    64'd0);
        check_val("rst_frame_done",  64'(frame_done),     64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sof = 1'b0; eof = 1'b0; dv = 1'b0; sd = 1'b0; din = '0; bpf = 32'd0;
        m_run = 1'b0; m_berr = 1'b0; m_cnt = 0; m_blocks = 0;
        hold_mean = '0; hold_var = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs();
            check_val("reset_data_out", 64'(data_out), 64'd0);
        end
        rst_n = 1'b1;

        // 1: constant block
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < NS; i++) step(1'b0, 1'b0, 1'b1, i == 0, pack3(100, 100, 100));
        idle(12);

        // 2: alternating / ramp / constant channels, checked against fixed numbers too
        for (int i = 0; i < NS; i++)
            step(1'b0, 1'b0, 1'b1, i == 0, pack3((i % 2) ? 255 : 0, i, 7));
        idle(12);
        check_val("t2_mean", 64'(mean_out),     64'({16'd7, 16'd3, 16'd127}));
        check_val("t2_var",  64'(variance_out), 64'({16'd0, 16'd8, 16'd16383}));

        // 3: two gapless blocks
        rand_block(1'b0);
        rand_block(1'b0);
        idle(14);

        // 4: two-block frame, third block must be ignored
        bpf = 32'd2;
        rand_block(1'b1);
        rand_block(1'b0);
        rand_block(1'b0);
        idle(14);
        bpf = 32'd0;

        // 5: end_of_frame discards a partial block
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, i == 0, PW'($urandom));
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(6);
        rand_block(1'b1);
        idle(12);

        // 6: start_data mid-block, then asynchronous reset mid-block
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i == 0, PW'($urandom));
        rand_block(1'b0);
        idle(12);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, i == 0, PW'($urandom));
        reset_mid_block();
        idle(4);
        rand_block(1'b1);
        idle(12);

        // 7: randomized traffic with gaps and occasional misplaced start_data
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 400; i++) begin
            bit r_dv, r_sd;
            r_dv = ($urandom_range(0, 9) < 7);
            if (m_cnt == 0) r_sd = ($urandom_range(0, 1) == 1);
            else            r_sd = ($urandom_range(0, 39) == 0);
            step(1'b0, 1'b0, r_dv, r_sd, PW'($urandom));
        end
        idle(14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
